// File: rtl/fdct_pkg.sv
// Types and helpers shared by the FDCT pipeline stages.
// The dot-product unit and the matrix collector both use this package.
package fdct_pkg;

    localparam int FDCT_N     = 8;
    localparam int FDCT_ELEMS = FDCT_N * FDCT_N;

    typedef logic [31:0]             float32_t;
    typedef float32_t [FDCT_N-1:0]   row_vec_t;
    typedef logic [2:0]              mat_idx_t;
    typedef logic [5:0]              elem_idx_t;

    typedef enum logic {
        RD_IDLE,
        RD_SEND
    } rd_state_t;

    typedef struct packed {
        mat_idx_t row;
        mat_idx_t col;
    } mat_pos_t;

    // Maps a serial element index to its matrix position.
    // With transpose set, row and column are swapped.
    function automatic mat_pos_t elem_pos(input elem_idx_t idx, input bit transpose);
        mat_pos_t pos;
        pos.row = transpose ? idx[2:0] : idx[5:3];
        pos.col = transpose ? idx[5:3] : idx[2:0];
        return pos;
    endfunction

endpackage

// File: rtl/dct_mat_bank.sv
// One 8x8 bank of DW-bit registers.
// It has a single-element write port and a combinational full-row read port.
module dct_mat_bank
    import fdct_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  mat_idx_t                   wr_row,
    input  mat_idx_t                   wr_col,
    input  logic [DW-1:0]              wr_data,
    input  mat_idx_t                   rd_row,
    output logic [FDCT_N-1:0][DW-1:0]  rd_data
);

    logic [FDCT_N-1:0][FDCT_N-1:0][DW-1:0] mem;

    // NOTE: the storage array is deliberately left out of reset. Every word
    // is written before it is read, so a reset here would only add fanout.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    assign rd_data = mem[rd_row];

endmodule

// File: rtl/dct_mat_collect.sv
// Collects the serial FDCT result stream into ping-pong 8x8 banks.
// Each completed block is re-emitted as 8 row vectors over valid/ready.
module dct_mat_collect
    import fdct_pkg::*;
#(
    parameter bit TRANSPOSE = 1'b0,
    parameter int DW        = 32
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [DW-1:0]              din,
    input  logic                       din_valid,
    output logic [FDCT_N-1:0][DW-1:0]  dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       dout_last,
    output logic                       overflow
);

    elem_idx_t  wr_idx;
    logic       wr_bank;
    logic       rd_bank;
    mat_idx_t   rd_row;
    logic [1:0] bank_full;
    rd_state_t  state;

    mat_pos_t   wr_pos;
    logic       wr_accept;
    logic       wr_last;
    logic       rd_done;

    logic [FDCT_N-1:0][DW-1:0] bank_rd [2];

    assign wr_pos    = elem_pos(wr_idx, TRANSPOSE);
    assign wr_accept = din_valid && !bank_full[wr_bank];
    assign wr_last   = (wr_idx == elem_idx_t'(FDCT_ELEMS - 1));
    assign rd_done   = dout_valid && dout_ready && (rd_row == mat_idx_t'(FDCT_N - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_mat_bank #(.DW(DW)) u_bank (
            .clk     (clk),
            .wr_en   (wr_accept && (wr_bank == 1'(b))),
            .wr_row  (wr_pos.row),
            .wr_col  (wr_pos.col),
            .wr_data (din),
            .rd_row  (rd_row),
            .rd_data (bank_rd[b])
        );
    end

    assign dout = bank_rd[rd_bank];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_idx   <= '0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else if (din_valid) begin
            if (!bank_full[wr_bank]) begin
                wr_idx <= wr_idx + 6'd1;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Set and clear never target the same bank: a bank is written only while
    // empty and read only while full, so both updates may land in one cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bank_full <= 2'b00;
        end else begin
            if (wr_accept && wr_last) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (rd_done) begin
                bank_full[rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= RD_IDLE;
            rd_bank    <= 1'b0;
            rd_row     <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        state      <= RD_SEND;
                        rd_row     <= '0;
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b0;
                    end
                end
                RD_SEND: begin
                    if (dout_ready) begin
                        if (rd_row == mat_idx_t'(FDCT_N - 1)) begin
                            state      <= RD_IDLE;
                            rd_row     <= '0;
                            rd_bank    <= ~rd_bank;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                        end else begin
                            rd_row    <= rd_row + 3'd1;
                            dout_last <= (rd_row == mat_idx_t'(FDCT_N - 2));
                        end
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_mat_collect.sv
// Directed bench for dct_mat_collect.
// A plain instance and a transposing instance share the same stimulus.
module tb_dct_mat_collect;

    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  nrst;
    logic [DW-1:0]         din;
    logic                  din_valid;
    logic                  dout_ready;
    logic [7:0][DW-1:0]    dout_n, dout_t;
    logic                  valid_n, valid_t, last_n, last_t, ovf_n, ovf_t;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dct_mat_collect #(.TRANSPOSE(1'b0), .DW(DW)) u_dut (
        .clk(clk), .nrst(nrst), .din(din), .din_valid(din_valid),
        .dout(dout_n), .dout_valid(valid_n), .dout_ready(dout_ready),
        .dout_last(last_n), .overflow(ovf_n)
    );

    dct_mat_collect #(.TRANSPOSE(1'b1), .DW(DW)) u_dut_t (
        .clk(clk), .nrst(nrst), .din(din), .din_valid(din_valid),
        .dout(dout_t), .dout_valid(valid_t), .dout_ready(dout_ready),
        .dout_last(last_t), .overflow(ovf_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compares the currently presented row of both instances.
    // The plain instance expects base+8r+c; the transposing one expects base+8c+r.
    task automatic row_check(input string tag, input int r, input int base);
        check($sformatf("%s_r%0d_valid", tag, r), 32'(valid_n), 32'd1);
        check($sformatf("%s_r%0d_valid_t", tag, r), 32'(valid_t), 32'd1);
        check($sformatf("%s_r%0d_last", tag, r), 32'(last_n), 32'(r == 7));
        check($sformatf("%s_r%0d_last_t", tag, r), 32'(last_t), 32'(r == 7));
        for (int c = 0; c < 8; c++) begin
            check($sformatf("%s_r%0d_c%0d", tag, r, c), dout_n[c], 32'(base + 8*r + c));
            check($sformatf("%s_r%0d_c%0d_t", tag, r, c), dout_t[c], 32'(base + 8*c + r));
        end
    endtask

    // Called at a falling edge: check the row, accept it, advance one cycle.
    task automatic take_row(input string tag, input int r, input int base);
        row_check(tag, r, base);
        dout_ready = 1'b1;
        @(negedge clk);
    endtask

    // Drives n back-to-back words starting at base.
    // Returns on the falling edge after the last word is registered.
    task automatic write_words(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            din       = 32'(base + k);
            din_valid = 1'b1;
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !valid_n; i++) @(negedge clk);
        check({tag, "_wait_valid"}, 32'(valid_n), 32'd1);
    endtask

    initial begin
        nrst       = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_valid",   32'(valid_n), 32'd0);
        check("rst_valid_t", 32'(valid_t), 32'd0);
        check("rst_last",    32'(last_n),  32'd0);
        check("rst_ovf",     32'(ovf_n),   32'd0);
        check("rst_ovf_t",   32'(ovf_t),   32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Basic: the first row appears two cycles after the 64th write, then 8 back-to-back rows.
        dout_ready = 1'b1;
        write_words(0, 64);
        check("basic_lat_n1", 32'(valid_n), 32'd0);
        @(negedge clk);
        for (int r = 0; r < 8; r++) take_row("basic", r, 0);
        check("basic_idle_after", 32'(valid_n), 32'd0);

        // Backpressure: hold row 3 for ten cycles, then drain.
        dout_ready = 1'b0;
        write_words(0, 64);
        wait_valid("bp");
        for (int r = 0; r < 3; r++) take_row("bp", r, 0);
        dout_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            row_check("bp_hold", 3, 0);
            @(negedge clk);
        end
        for (int r = 3; r < 8; r++) take_row("bp", r, 0);
        check("bp_idle_after", 32'(valid_n), 32'd0);

        // Ping-pong: two blocks back to back, with ready toggling every cycle.
        dout_ready = 1'b0;
        fork
            begin
                write_words(0, 64);
                write_words(100, 64);
            end
            begin
                int  rows = 0;
                logic rdy = 1'b0;
                for (int cyc = 0; cyc < 400 && rows < 16; cyc++) begin
                    rdy        = ~rdy;
                    dout_ready = rdy;
                    if (valid_n && rdy) begin
                        row_check("pp", rows % 8, (rows < 8) ? 0 : 100);
                        rows++;
                    end
                    @(negedge clk);
                end
                check("pp_rows", 32'(rows), 32'd16);
            end
        join
        check("pp_ovf",   32'(ovf_n), 32'd0);
        check("pp_ovf_t", 32'(ovf_t), 32'd0);

        // Overflow: both banks fill, the 129th word is dropped, and the flag is sticky.
        dout_ready = 1'b0;
        write_words(0, 128);
        check("ovf_before", 32'(ovf_n), 32'd0);
        write_words(128, 1);
        check("ovf_set",   32'(ovf_n), 32'd1);
        check("ovf_set_t", 32'(ovf_t), 32'd1);
        wait_valid("ovf_a");
        for (int r = 0; r < 8; r++) take_row("ovf_a", r, 0);
        wait_valid("ovf_b");
        for (int r = 0; r < 8; r++) take_row("ovf_b", r, 64);
        check("ovf_drained", 32'(valid_n), 32'd0);
        check("ovf_sticky",  32'(ovf_n),   32'd1);

        // Reset mid-operation: one block is in flight while reading row 2,
        // with 20 words of the next block written.
        dout_ready = 1'b0;
        write_words(0, 64);
        write_words(200, 20);
        wait_valid("mid");
        for (int r = 0; r < 2; r++) take_row("mid", r, 0);
        dout_ready = 1'b0;
        row_check("mid_hold", 2, 0);
        nrst = 1'b0;
        #1;
        check("mid_rst_valid",   32'(valid_n), 32'd0);
        check("mid_rst_valid_t", 32'(valid_t), 32'd0);
        check("mid_rst_ovf",     32'(ovf_n),   32'd0);
        check("mid_rst_ovf_t",   32'(ovf_t),   32'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_stale", 32'(valid_n), 32'd0);
        dout_ready = 1'b1;
        write_words(0, 64);
        check("mid_lat_n1", 32'(valid_n), 32'd0);
        @(negedge clk);
        for (int r = 0; r < 8; r++) take_row("mid_after", r, 0);
        check("mid_idle_after", 32'(valid_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dct_mat_collect.md
Name: dct_mat_collect

Overview:
- Downstream neighbour of the FDCT dot-product unit. Captures its serial stream of 32-bit IEEE-754 single-precision results, one word per dout_valid pulse, into an 8x8 matrix.
- Re-emits the matrix as 8 row vectors of 8 words over a valid/ready handshake. The row-vector form is what the next matrix-multiply pass or the quantiser needs.
- Storage is ping-pong double-buffered, so one block is written while the previous block is read.
- The optional transpose on write turns the first-pass (rows) result into second-pass column order.

Parameters:
- TRANSPOSE, 0, when 1 the incoming element k is stored at [k%8][k/8] instead of [k/8][k%8].
- DW, 32, data word width; data is opaque to this block and never arithmetically modified.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- din  in  DW  result word from the dot-product stage
- din_valid  in  1  din qualifier, single-cycle pulses, no backpressure possible
- dout  out  DW x [7:0]  current row vector
- dout_valid  out  1  dout holds a valid row
- dout_ready  in  1  consumer accepts the row when high with dout_valid
- dout_last  out  1  high with dout_valid on row 7
- overflow  out  1  sticky: a word arrived while both banks were full

Behaviour:
- Reset (nrst low, async):
  - wr_idx=0, wr_bank=0, rd_bank=0, rd_row=0, bank_full[1:0]=0, overflow=0.
  - dout_valid=0, dout_last=0.
  - dout is don't-care. Storage contents are not reset.
- Storage: two banks of 8x8 DW-bit registers (flops, no RAM), so a full row is readable in one cycle.
- Write side:
  - On din_valid with bank_full[wr_bank]=0: store din at row wr_idx[5:3], col wr_idx[2:0]. Row/col are swapped when TRANSPOSE=1. Then increment wr_idx (6-bit).
  - When wr_idx==63 and the write is accepted: set bank_full[wr_bank], wr_idx wraps to 0, wr_bank toggles.
  - On din_valid with bank_full[wr_bank]=1: the word is dropped, overflow is set (sticky until reset), and wr_idx is unchanged.
- Read side, FSM states IDLE and SEND:
  - IDLE: when bank_full[rd_bank]=1, go to SEND with rd_row=0.
  - SEND: dout_valid=1. dout[c] = bank[rd_bank][rd_row][c]. dout_last = (rd_row==7).
  - On dout_valid && dout_ready:
    - rd_row<7: rd_row++, stay in SEND.
    - rd_row==7: clear bank_full[rd_bank], toggle rd_bank, rd_row=0, go to IDLE.
  - Holding dout_ready low keeps dout and dout_valid stable for any number of cycles.
- Latency:
  - The 64th write in cycle N registers bank_full in N+1. dout_valid is first high in cycle N+2 (IDLE->SEND transition).
  - With dout_ready held high, one row is emitted per cycle: 8 cycles per block, then one IDLE cycle.
- Simultaneous events:
  - Read frees a bank in the same cycle a write fills the other bank: both updates take effect, with no conflict since the bank indices differ.
  - Read frees bank B in the same cycle a word arrives for bank B while it is full: the word is dropped and overflow is set. The full check uses the pre-update value.
- Write and read of the same bank never overlap, because a bank is written only while not full and read only while full.
- Reset mid-block: any partial write or partial read is discarded. The next din_valid after reset is element 0 of bank 0.

Decomposition:
- Shared package fdct_pkg:
  - FDCT_N=8, FDCT_ELEMS=64, word typedef float32_t (logic [31:0]).
  - row_vec_t (float32_t [7:0]), so dot-product inputs and this block's output share one type.
- Sub-module dct_mat_bank: one 8x8 register bank with write port (en, row, col, data) and a combinational full-row read port. Instantiated twice.
- The FSM, pointers and overflow logic stay in the top.

Test Plan:
- Basic: 64 pulses din=k (k=0..63), TRANSPOSE=0, dout_ready=1 -> first dout_valid 2 cycles after the last write; row r dout[c]=8r+c; dout_last only on row 7; 8 consecutive valid cycles.
- Transpose: same stimulus, TRANSPOSE=1 -> row r dout[c]=8c+r (row 0 = 0,8,...,56).
- Backpressure: dout_ready low for 10 cycles on row 3 -> dout stays 24..31 and dout_valid stays 1; release -> rows 4..7 follow, no loss.
- Ping-pong: block A (k) and then block B (100+k) back to back, with dout_ready toggling every cycle -> A rows, then B rows, in order; overflow=0.
- Overflow: dout_ready=0, send 129 words -> banks hold 0..63 and 64..127, word 128 dropped, overflow=1; then ready=1 -> 16 rows output, overflow stays 1.
- Reset mid-op: assert nrst low after 20 writes and during a read of row 2 -> dout_valid=0, overflow=0; then 64 words k -> output matches the Basic case from bank 0.
